scaler_v_ctrl: RTL and testbench
================================

// Module: scaler_v_ctrl
// PURPOSE
//  Configuration controller for the vertical line scaler. Measures incoming frame geometry
//  (lines/frame, pixels/line) from the de/hs/vs strobes and computes scale_step =
//  lines_in*LINE_STEP/lines_out with a sequential divider.
//  Applies new step/line size only at frame start, so the scaler sees constant settings per frame.
// PARAMETERS
//  LINE_STEP        4096  fixed-point 1.000 of scale_step; power of two
//  LINE_IN_SIZE_MAX 1024  max pixels/line; longer lines flag cfg_err
//  DIV_W            16+$clog2(LINE_STEP)  dividend/divider width (derived, do not override)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous reset, active low
//  cfg_lines_out in   16  requested output lines per frame
//  cfg_wr        in   1   1-cycle strobe: sample cfg_lines_out, request recompute
//  de_i          in   1   input pixel valid; hs_i/vs_i qualified by de_i
//  hs_i          in   1   first pixel of line (with de_i)
//  vs_i          in   1   first pixel of frame (with de_i; hs_i also high)
//  scale_step    out  16  to scaler: unsigned fixed-point step
//  line_in_size  out  16  to scaler: pixels per line minus 1
//  frame_lines   out  16  measured lines in last complete frame
//  cfg_busy      out  1   divider running or result awaiting frame start
//  cfg_err       out  1   sticky: lines_out==0, quotient>16 bits, or line>LINE_IN_SIZE_MAX
// BEHAVIOUR
//  Reset: scale_step=LINE_STEP, line_in_size=0, frame_lines=0, cfg_busy=0, cfg_err=0, FSM=IDLE,
//   lines_out_r=0, frame_valid=0. rst_n is async assert; deassert is sync to clk.
//  Measure: pix_cnt +1 per de_i, reset to 1 on de_i&hs_i; line_cnt +1 per de_i&hs_i.
//   On de_i&vs_i with frame_valid=1: frame_lines<=line_cnt and meas_size<=first-line pix_cnt-1,
//   then line_cnt<=1. frame_valid is set at the first vs. The partial frame before it is discarded.
//  FSM IDLE -> DIV: on a new frame_lines value != previous, or cfg_wr, when frame_valid=1.
//  DIV: restoring divider, dividend={frame_lines,log2(LINE_STEP) zeros}, divisor=lines_out_r,
//   1 quotient bit/cycle, exactly DIV_W cycles, then -> CHECK.
//  CHECK: if lines_out_r==0 or quotient>16'hFFFF: set cfg_err, discard result, go to IDLE.
//   Otherwise latch step_pend and go to WAIT.
//  WAIT: on the next de_i&vs_i, in the following cycle, scale_step<=step_pend and
//   line_in_size<=meas_size; -> IDLE.
//  cfg_busy=1 in DIV, CHECK and WAIT.
//  cfg_wr while busy: value is captured, pend flag set. Current op is abandoned at end of DIV;
//   division restarts with the new value. scale_step is never driven from a stale lines_out.
//  cfg_wr and a frame latch in the same cycle: one recompute uses both new values.
//  line_in_size updates even if the step is unchanged. It applies only at vs, never mid-frame.
//  Counters saturate at 16'hFFFF. pix_cnt>LINE_IN_SIZE_MAX sets cfg_err; meas_size is clamped
//   to LINE_IN_SIZE_MAX-1.
//  cfg_err clears only by reset, or by cfg_wr with a valid value that completes without error.
// CONFIGURATION
//  SCALER_V_CTRL_ROUND_EN defined: dividend += lines_out_r>>1 before dividing (round to nearest).
//  Not defined: plain floor division. Latency is identical in both builds.
// TESTING
//  1 After reset: scale_step=4096 and cfg_busy=0 before any vs.
//  2 8-line frames, cfg_wr lines_out=16: after the 2nd vs, cfg_busy rises.
//    At the following vs, scale_step=2048.
//  3 Frames of 2 lines, lines_out=3: scale_step=2730; with ROUND_EN, 2731.
//  4 Frames of 1000 lines, lines_out=1: cfg_err=1 and scale_step unchanged.
//    cfg_wr lines_out=0 also sets cfg_err.
//  5 Line of 640 pixels: line_in_size=639, updated only in the cycle after de_i&vs_i.
//  6 cfg_wr during DIV, then rst_n low mid-DIV: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/scaler_v_ctrl.sv
// scaler_v_ctrl: vertical scaler config controller, frame geometry measurement and step divider.
// Define SCALER_V_CTRL_ROUND_EN for a round-to-nearest scale_step instead of floor.
module scaler_v_ctrl #(
    parameter int LINE_STEP        = 4096,
    parameter int LINE_IN_SIZE_MAX = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cfg_lines_out,
    input  logic        cfg_wr,
    input  logic        de_i,
    input  logic        hs_i,
    input  logic        vs_i,
    output logic [15:0] scale_step,
    output logic [15:0] line_in_size,
    output logic [15:0] frame_lines,
    output logic        cfg_busy,
    output logic        cfg_err
);
    localparam int SH = $clog2(LINE_STEP);
    localparam int DIV_W = 16 + SH;
    localparam int CW = $clog2(DIV_W);
    localparam logic [CW-1:0] LAST = CW'(DIV_W - 1);
    localparam logic [15:0] SIZE_MAX = 16'(LINE_IN_SIZE_MAX);

    typedef enum logic [1:0] {IDLE, DIV, CHECK, WAIT} state_t;
    state_t state;

    logic [15:0] pix_cnt, line_cnt, first_pix, meas_size, lines_out_r, step_pend, rem;
    logic [15:0] first_src, meas_nxt, sub;
    logic [DIV_W-1:0] dvd, dvd_init;
    logic [CW-1:0] cnt;
    logic [16:0] sh;
    logic frame_valid, wr_pend, chg_pend, wr_op, vs_d;
    logic latch, q_bit, bad, chk_ok, go, err_set, err_clr;

    assign cfg_busy = state != IDLE;

    always_comb begin
        latch     = de_i && vs_i && frame_valid;
        first_src = (line_cnt == 16'd1) ? pix_cnt : first_pix;
        meas_nxt  = (first_src > SIZE_MAX) ? SIZE_MAX - 16'd1 : first_src - 16'd1;
        sh        = {rem, dvd[DIV_W-1]};
        q_bit     = sh >= {1'b0, lines_out_r};
        sub       = sh[15:0] - lines_out_r;
        bad       = (lines_out_r == 16'd0) || (|dvd[DIV_W-1:16]);
        chk_ok    = state == CHECK && !wr_pend;
        // a pending cfg_wr abandons any result computed from the old lines_out
        go        = (wr_pend && (state == CHECK || state == WAIT || (state == DIV && cnt == LAST)))
                 || (state == IDLE && frame_lines != 16'd0 && (wr_pend || chg_pend));
        err_set   = (frame_valid && pix_cnt > SIZE_MAX) || (chk_ok && bad);
        err_clr   = chk_ok && !bad && wr_op;
`ifdef SCALER_V_CTRL_ROUND_EN
        dvd_init  = '0;
        begin
            logic [DIV_W:0] dvd_sum;
            dvd_sum  = {1'b0, frame_lines, {SH{1'b0}}} + {{(DIV_W-14){1'b0}}, lines_out_r[15:1]};
            dvd_init = dvd_sum[DIV_W] ? '1 : dvd_sum[DIV_W-1:0];
        end
`else
        dvd_init  = {frame_lines, {SH{1'b0}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            scale_step   <= 16'(LINE_STEP);
            line_in_size <= '0;
            frame_lines  <= '0;
            cfg_err      <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            first_pix    <= '0;
            meas_size    <= '0;
            lines_out_r  <= '0;
            step_pend    <= '0;
            rem          <= '0;
            dvd          <= '0;
            cnt          <= '0;
            frame_valid  <= 1'b0;
            wr_pend      <= 1'b0;
            chg_pend     <= 1'b0;
            wr_op        <= 1'b0;
            vs_d         <= 1'b0;
        end else begin
            if (de_i)
                pix_cnt <= hs_i ? 16'd1 : (&pix_cnt ? pix_cnt : pix_cnt + 16'd1);
            if (de_i && vs_i) begin
                line_cnt    <= 16'd1;
                frame_valid <= 1'b1;
                if (frame_valid) begin
                    frame_lines <= line_cnt;
                    meas_size   <= meas_nxt;
                end
            end else if (de_i && hs_i) begin
                line_cnt <= &line_cnt ? line_cnt : line_cnt + 16'd1;
                if (line_cnt == 16'd1)
                    first_pix <= pix_cnt;
            end
            vs_d <= latch;
            if (vs_d)
                line_in_size <= meas_size;
            if (cfg_wr)
                lines_out_r <= cfg_lines_out;
            wr_pend  <= cfg_wr || (wr_pend && !go);
            chg_pend <= (latch && line_cnt != frame_lines) || (chg_pend && !go);
            cfg_err  <= err_set || (cfg_err && !err_clr);
            if (go) begin
                state <= DIV;
                cnt   <= '0;
                rem   <= '0;
                dvd   <= dvd_init;
                wr_op <= wr_pend;
            end else begin
                case (state)
                    DIV: begin
                        rem <= q_bit ? sub : sh[15:0];
                        dvd <= {dvd[DIV_W-2:0], q_bit};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= CHECK;
                    end
                    CHECK: begin
                        step_pend <= dvd[15:0];
                        state     <= bad ? IDLE : WAIT;
                    end
                    WAIT: if (vs_d) begin
                        scale_step <= step_pend;
                        state      <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scaler_v_ctrl.sv
// tb_scaler_v_ctrl: table-driven and directed checks of scaler_v_ctrl.
module tb_scaler_v_ctrl;
`ifdef SCALER_V_CTRL_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_lines_out = '0;
    logic        cfg_wr = 1'b0;
    logic        de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [15:0] scale_step, line_in_size, frame_lines;
    logic        cfg_busy, cfg_err;

    int n_chk = 0;
    int n_fail = 0;

    scaler_v_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_lines_out(cfg_lines_out), .cfg_wr(cfg_wr),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .scale_step(scale_step),
        .line_in_size(line_in_size), .frame_lines(frame_lines),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lines;
        int ppl;
        int lout;
        int step;
        int err;
        int size;
    } vec_t;
    vec_t v[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic d, input logic h, input logic s);
        de_i = d;
        hs_i = h;
        vs_i = s;
        @(negedge clk);
    endtask

    task automatic frame(input int lines, input int ppl, input int from);
        for (int k = from; k < lines * ppl; k++)
            cyc(1'b1, k % ppl == 0, k == 0);
    endtask

    task automatic cfg(input int lo);
        de_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
        cfg_lines_out = 16'(lo);
        cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        de_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
        cfg_wr = 1'b0;
        cfg_lines_out = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        v[0] = '{8, 8, 16, 2048, 0, 7};
        v[1] = '{2, 8, 3, RND ? 2731 : 2730, 0, 7};
        v[2] = '{1000, 2, 1, 4096, 1, 1};
        v[3] = '{4, 640, 4, 4096, 0, 639};
        v[4] = '{3, 4, 2, 6144, 0, 3};
        v[5] = '{16, 4, 8, 8192, 0, 3};
        v[6] = '{1, 4, 2, 2048, 0, 3};
        v[7] = '{5, 2, 0, 4096, 1, 1};
        v[8] = '{1, 1100, 1, 4096, 1, 1023};

        do_reset();
        chk("rst_step", scale_step, 4096);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_size", line_in_size, 0);
        chk("rst_lines", frame_lines, 0);
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        chk("novs_busy", cfg_busy, 0);
        chk("novs_step", scale_step, 4096);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            cfg(v[i].lout);
            frame(v[i].lines, v[i].ppl, 0);
            frame(v[i].lines, v[i].ppl, 0);
            repeat (40) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b1);
            cyc(1'b1, 1'b0, 1'b0);
            chk($sformatf("v%0d_step", i), scale_step, v[i].step);
            chk($sformatf("v%0d_err", i), cfg_err, v[i].err);
            chk($sformatf("v%0d_size", i), line_in_size, v[i].size);
            chk($sformatf("v%0d_lines", i), frame_lines, v[i].lines);
            chk($sformatf("v%0d_busy", i), cfg_busy, 0);
        end

        // busy rises right after the 2nd vs; step applies the cycle after the 3rd vs
        do_reset();
        cfg(16);
        frame(8, 8, 0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("vs2_lines", frame_lines, 8);
        chk("vs2_busy0", cfg_busy, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("vs2_busy1", cfg_busy, 1);
        frame(8, 8, 2);
        chk("wait_busy", cfg_busy, 1);
        chk("wait_step", scale_step, 4096);
        cyc(1'b1, 1'b1, 1'b1);
        chk("vs3_step_old", scale_step, 4096);
        cyc(1'b1, 1'b0, 1'b0);
        chk("vs3_step_new", scale_step, 2048);
        chk("vs3_busy", cfg_busy, 0);

        // line size applies only the cycle after vs
        do_reset();
        frame(2, 640, 0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("size_at_vs", line_in_size, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("size_after_vs", line_in_size, 639);

        // cfg_err clears on a good cfg_wr, is set again by lines_out=0, stale step never applied
        do_reset();
        cfg(1);
        frame(1000, 2, 0);
        frame(1000, 2, 0);
        chk("big_err", cfg_err, 1);
        chk("big_step", scale_step, 4096);
        cfg(500);
        repeat (40) cyc(1'b0, 1'b0, 1'b0);
        chk("clr_err", cfg_err, 0);
        chk("clr_busy", cfg_busy, 1);
        cfg(0);
        repeat (40) cyc(1'b0, 1'b0, 1'b0);
        chk("zero_err", cfg_err, 1);
        chk("zero_busy", cfg_busy, 0);
        chk("zero_step", scale_step, 4096);

        // cfg_wr mid-DIV restarts the division with the new value
        do_reset();
        cfg(16);
        frame(8, 16, 0);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        cfg(4);
        frame(8, 16, 6);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart_step", scale_step, 8192);
        chk("restart_busy", cfg_busy, 0);

        // asynchronous reset in the middle of DIV
        do_reset();
        cfg(16);
        frame(8, 8, 0);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        cfg(32);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("pre_rst_busy", cfg_busy, 1);
        chk("pre_rst_lines", frame_lines, 8);
        chk("pre_rst_size", line_in_size, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", cfg_busy, 0);
        chk("arst_lines", frame_lines, 0);
        chk("arst_size", line_in_size, 0);
        chk("arst_step", scale_step, 4096);
        chk("arst_err", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
